// File: rtl/dm_ctrl_pkg.sv
// dm_ctrl_pkg: shared command-FSM states, abstractcs error codes and timeout default
package dm_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GO   = 2'd1,
    EXEC = 2'd2
  } cmd_state_e;
  typedef enum logic [2:0] {
    NONE       = 3'd0,
    BUSY       = 3'd1,
    NOTSUP     = 3'd2,
    EXCEPTION  = 3'd3,
    HALTRESUME = 3'd4,
    OTHER      = 3'd7
  } cmderr_e;
  localparam int unsigned DefaultTimeoutCycles = 1024;
endpackage

// File: rtl/dm_timeout_cnt.sv
// dm_timeout_cnt: clearable up-counter flagging the last allowed cycle of a wait phase
module dm_timeout_cnt #(
  parameter int unsigned Cycles = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned W = $clog2(Cycles);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else if (clear_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + W'(1);
  end
  assign expired_o = en_i && cnt_q == W'(Cycles - 1);
endmodule

// File: rtl/dm_abs_cmd_seq.sv
// dm_abs_cmd_seq: abstract-command and resume handshake sequencer; define DM_CMD_TIMEOUT_EN for per-phase hart timeout
module dm_abs_cmd_seq
  import dm_ctrl_pkg::*;
#(
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  input  logic       cmd_supported_i,
  input  logic       resumereq_i,
  input  logic       clear_resumeack_i,
  input  logic       wr_halted_en_i,
  input  logic       wr_going_en_i,
  input  logic       wr_resuming_en_i,
  input  logic       wr_exception_en_i,
  output logic       go_o,
  output logic       resume_o,
  output logic       halted_o,
  output logic       resumeack_o,
  output logic       cmdbusy_o,
  output logic       cmderror_valid_o,
  output logic [2:0] cmderror_o
);
  cmd_state_e state_q, state_n;
  cmderr_e err_q, err_n;
  logic err_valid_n, err_valid_q, halted_q, resume_q, resumeack_q, go_q, busy_q;
  logic timeout, resume_go;
  if (TimeoutCycles < 2) begin : g_bad_cfg
    $error("dm_abs_cmd_seq: TimeoutCycles must be >= 2");
  end
`ifdef DM_CMD_TIMEOUT_EN
  dm_timeout_cnt #(.Cycles(TimeoutCycles)) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_q == IDLE || state_n != state_q),
    .en_i     (state_q != IDLE),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  // a hart acknowledgment in the same cycle always beats the timeout
  always_comb begin
    state_n = state_q;
    err_valid_n = 1'b0;
    err_n = err_q;
    if (cmd_valid_i && state_q == IDLE) begin
      if (!cmd_supported_i) begin
        err_valid_n = 1'b1;
        err_n = NOTSUP;
      end else if (!halted_q) begin
        err_valid_n = 1'b1;
        err_n = HALTRESUME;
      end else begin
        state_n = GO;
      end
    end
    if (cmd_valid_i && state_q != IDLE) begin
      err_valid_n = 1'b1;
      err_n = BUSY;
    end
    if (state_q != IDLE) begin
      if (wr_exception_en_i) begin
        state_n = IDLE;
        err_valid_n = 1'b1;
        err_n = EXCEPTION;
      end else if (state_q == GO && wr_going_en_i) begin
        state_n = EXEC;
      end else if (state_q == EXEC && wr_halted_en_i) begin
        state_n = IDLE;
      end else if (timeout) begin
        state_n = IDLE;
        err_valid_n = 1'b1;
        err_n = OTHER;
      end
    end
  end
  assign resume_go = state_q == IDLE && halted_q && resumereq_i && !cmd_valid_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      err_q       <= NONE;
      err_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      resume_q    <= 1'b0;
      resumeack_q <= 1'b0;
      go_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      err_q       <= err_n;
      err_valid_q <= err_valid_n;
      halted_q    <= wr_halted_en_i ? 1'b1 : wr_resuming_en_i ? 1'b0 : halted_q;
      resume_q    <= wr_resuming_en_i ? 1'b0 : resume_go ? 1'b1 : resume_q;
      resumeack_q <= wr_resuming_en_i ? 1'b1 : (resume_go || clear_resumeack_i) ? 1'b0 : resumeack_q;
      go_q        <= state_n == GO;
      busy_q      <= state_n != IDLE;
    end
  end
  assign go_o             = go_q;
  assign resume_o         = resume_q;
  assign halted_o         = halted_q;
  assign resumeack_o      = resumeack_q;
  assign cmdbusy_o        = busy_q;
  assign cmderror_valid_o = err_valid_q;
  assign cmderror_o       = err_q;
endmodule

// File: tb/tb_dm_abs_cmd_seq.sv
// tb_dm_abs_cmd_seq: directed plus random stimulus against a phase-level reference model
module tb_dm_abs_cmd_seq;
  localparam int T = 8;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic cmd_valid = 0, cmd_supported = 0, resumereq = 0, clear_resumeack = 0;
  logic wr_halted = 0, wr_going = 0, wr_resuming = 0, wr_exception = 0;
  logic go, resume, halted, resumeack, cmdbusy, errv;
  logic [2:0] errc;
  int checks = 0, fails = 0;
  int ph = 0, age = 0;
  logic m_halted, m_resume, m_ack, m_go, m_busy, m_errv;
  logic [2:0] m_errc;

  dm_abs_cmd_seq #(.TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid), .cmd_supported_i(cmd_supported),
    .resumereq_i(resumereq), .clear_resumeack_i(clear_resumeack), .wr_halted_en_i(wr_halted),
    .wr_going_en_i(wr_going), .wr_resuming_en_i(wr_resuming), .wr_exception_en_i(wr_exception),
    .go_o(go), .resume_o(resume), .halted_o(halted), .resumeack_o(resumeack), .cmdbusy_o(cmdbusy),
    .cmderror_valid_o(errv), .cmderror_o(errc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; age = 0;
    {m_halted, m_resume, m_ack, m_go, m_busy, m_errv} = '0;
    m_errc = 3'd0;
  endtask

  // phases: 0 idle, 1 waiting for GOING, 2 waiting for HALTED
  task automatic model_step();
    int nph = ph;
    bit ev = 0, rgo;
    logic [2:0] code = 3'd0;
    if (cmd_valid) begin
      if (ph != 0) begin ev = 1; code = 3'd1; end
      else if (!cmd_supported) begin ev = 1; code = 3'd2; end
      else if (!m_halted) begin ev = 1; code = 3'd4; end
      else nph = 1;
    end
    if (ph != 0) begin
      if (wr_exception) begin ev = 1; code = 3'd3; nph = 0; end
      else if (ph == 1 && wr_going) nph = 2;
      else if (ph == 2 && wr_halted) nph = 0;
`ifdef DM_CMD_TIMEOUT_EN
      else if (age == T - 1) begin ev = 1; code = 3'd7; nph = 0; end
`endif
    end
    rgo = ph == 0 && m_halted && resumereq && !cmd_valid;
    if (wr_resuming) begin m_resume = 0; m_ack = 1; end
    else if (rgo) begin m_resume = 1; m_ack = 0; end
    else if (clear_resumeack) m_ack = 0;
    if (wr_halted) m_halted = 1;
    else if (wr_resuming) m_halted = 0;
    age = (nph != ph) ? 0 : age + 1;
    ph = nph;
    m_go = ph == 1;
    m_busy = ph != 0;
    m_errv = ev;
    if (ev) m_errc = code;
  endtask

  task automatic compare_all();
    chk("go", go, m_go);
    chk("resume", resume, m_resume);
    chk("halted", halted, m_halted);
    chk("resumeack", resumeack, m_ack);
    chk("cmdbusy", cmdbusy, m_busy);
    chk("errvalid", errv, m_errv);
    chk("errcode", errc, m_errc);
  endtask

  task automatic step(input bit cv, cs, rr, cr, wh, wg, wrs, we);
    {cmd_valid, cmd_supported, resumereq, clear_resumeack} = {cv, cs, rr, cr};
    {wr_halted, wr_going, wr_resuming, wr_exception} = {wh, wg, wrs, we};
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    {cmd_valid, cmd_supported, resumereq, clear_resumeack} = '0;
    {wr_halted, wr_going, wr_resuming, wr_exception} = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_busy", cmdbusy, 0);
    chk("reset_errc", errc, 0);
    do_reset();
    //            cv cs rr cr wh wg wrs we
    step(0,0,0,0,1,0,0,0); chk("halt_set", halted, 1);
    step(1,1,0,0,0,0,0,0); chk("cmd_go", go, 1); chk("cmd_busy", cmdbusy, 1);
    step(0,0,0,0,0,1,0,0); chk("going_go", go, 0); chk("going_busy", cmdbusy, 1);
    step(0,0,0,0,1,0,0,0); chk("done_busy", cmdbusy, 0); chk("done_noerr", errv, 0);
    step(0,0,0,0,0,0,1,0);
    step(1,1,0,0,0,0,0,0); chk("nothalt_ev", errv, 1); chk("nothalt_code", errc, 4); chk("nothalt_busy", cmdbusy, 0);
    step(0,0,0,0,0,0,0,0); chk("pulse_once", errv, 0); chk("code_held", errc, 4);
    step(0,0,0,0,1,0,0,0);
    step(1,0,0,0,0,0,0,0); chk("notsup_code", errc, 2);
    step(1,1,0,0,0,0,0,0);
    step(0,0,0,0,0,1,0,0);
    step(1,1,0,0,0,0,0,0); chk("busy_code", errc, 1); chk("busy_still", cmdbusy, 1);
    step(0,0,0,0,1,0,0,0); chk("busy_done", cmdbusy, 0);
    step(1,1,0,0,0,0,0,0);
    step(0,0,0,0,0,1,0,0);
    step(0,0,0,0,1,0,0,1); chk("exc_code", errc, 3); chk("exc_idle", cmdbusy, 0);
    step(0,0,1,0,0,0,0,0); chk("resume_set", resume, 1);
    step(0,0,0,0,0,0,1,0); chk("resume_clr", resume, 0); chk("resume_ack", resumeack, 1); chk("resume_unhalt", halted, 0);
    step(0,0,0,1,0,0,0,0); chk("ack_clr", resumeack, 0);
`ifdef DM_CMD_TIMEOUT_EN
    step(0,0,0,0,1,0,0,0);
    step(1,1,0,0,0,0,0,0);
    repeat (T - 1) step(0,0,0,0,0,0,0,0);
    chk("to_busy_before", cmdbusy, 1);
    step(0,0,0,0,0,0,0,0); chk("to_code", errc, 7); chk("to_ev", errv, 1); chk("to_go", go, 0);
`endif
    step(0,0,0,0,1,0,0,0);
    step(1,1,0,0,0,0,0,0);
    @(negedge clk);
    do_reset();
    chk("midreset_go", go, 0);
    chk("midreset_halted", halted, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(5) == 0, $urandom_range(3) != 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
           $urandom_range(4) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0, $urandom_range(11) == 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
